// File: rtl/mult4_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM encoding, default width
// and counter-width helper.
package mult4_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } mult_state_e;

    localparam int unsigned DefaultN = 4;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DefaultCntW = cnt_width(DefaultN);

endpackage

// File: rtl/add4.sv
// 4-bit ripple-carry adder; c3 is the carry out of the most significant bit.
module add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       c3
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < 4; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        c3 = c[4];
    end

endmodule

// File: rtl/mult4_seq.sv
// Sequential shift-and-add unsigned multiplier, N x N -> 2N, valid/ready on both sides.
// Optional macro MULT4_ZERO_SKIP_EN: zero operands bypass the iterations and finish at once.
module mult4_seq
    import mult4_pkg::*;
#(
    parameter int unsigned N = DefaultN
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a_in,
    input  logic [N-1:0]   b_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product
);

    localparam int unsigned CntW = cnt_width(N);

    mult_state_e     state_q, state_d;
    logic [N-1:0]    acc_q, acc_d;
    logic [N-1:0]    q_q, q_d;
    logic [N-1:0]    m_q, m_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [N-1:0]    addend;
    logic [N-1:0]    sum;
    logic            carry;

    assign addend = q_q[0] ? m_q : '0;

    generate
        if (N == 4) begin : g_add4
            add4 u_add4 (
                .a  (acc_q),
                .b  (addend),
                .ci (1'b0),
                .s  (sum),
                .c3 (carry)
            );
        end else begin : g_add_beh
            assign {carry, sum} = {1'b0, acc_q} + {1'b0, addend};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        q_d       = q_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        product   = '0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    m_d     = a_in;
                    q_d     = b_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StCalc;
`ifdef MULT4_ZERO_SKIP_EN
                    if (a_in == '0 || b_in == '0) begin
                        q_d     = '0;
                        state_d = StDone;
                    end
`endif
                end
            end
            StCalc: begin
                // Keep the adder carry: shift {carry,sum,Q} right by one into {acc,Q}.
                acc_d = {carry, sum[N-1:1]};
                q_d   = {sum[0], q_q[N-1:1]};
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(N - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                product   = {acc_q, q_q};
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule
